boot_sequencer: RTL and testbench
=================================

Name: boot_sequencer

Overview:
- Sequences the Hack CPU core: loads program words into instruction ROM from a byte stream, holds the CPU in reset while loading, then releases it.
- Provides run/halt/single-step control via a clock-enable, plus a count of enabled cycles.
- Sits between the host/UART byte source and the CPU, ROM write port and CPU reset/enable inputs.

Parameters:
- ADDR_W, 15, ROM address width; capacity 2**ADDR_W words.
- CNT_W, 32, width of the enabled-cycle counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- load_req  in  1  single-cycle pulse: start program load
- len_words  in  16  word count for the load, sampled with load_req
- byte_valid  in  1  source byte valid
- byte_data  in  8  source byte
- byte_ready  out  1  sequencer accepts byte this cycle
- rom_we  out  1  ROM write strobe
- rom_addr  out  ADDR_W  ROM write address
- rom_wdata  out  16  ROM write data
- cpu_rst  out  1  reset to CPU registers and PC
- cpu_en  out  1  CPU clock-enable; gates register, PC and writeM updates
- run_req  in  1  pulse: free-run
- halt_req  in  1  pulse: stop
- step_req  in  1  pulse: execute one instruction while halted
- load_done  out  1  one-cycle pulse after the final ROM write
- load_err  out  1  one-cycle pulse when len_words is illegal
- cyc_count  out  CNT_W  cycles with cpu_en=1 since last START
- state_o  out  3  current state encoding

Behaviour:
- All outputs registered.
- Reset (async): state IDLE, cpu_rst=1, cpu_en=0, byte_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, load_done=0, load_err=0, cyc_count=0.
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, START, RUN, HALT, STEP.
- Request priority when requests coincide: load_req > halt_req > run_req > step_req.
- load_req in IDLE/RUN/HALT/STEP:
  - Legal len_words is 1..2**ADDR_W: latch count, rom_addr=0, cpu_rst=1, cpu_en=0, go to LOAD_HI.
  - Otherwise: pulse load_err, state unchanged.
  - load_req is ignored in LOAD_HI, LOAD_LO, WRITE and START.
- LOAD_HI: byte_ready=1. On byte_valid&byte_ready, capture byte_data as rom_wdata[15:8] and go to LOAD_LO.
- LOAD_LO: byte_ready=1. Capture rom_wdata[7:0] on handshake, then go to WRITE.
- Word format is big-endian. byte_valid without ready has no effect and the byte is not consumed.
- WRITE: byte_ready=0, rom_we=1 for exactly one cycle with the current rom_addr and rom_wdata.
  - If rom_addr == count-1: pulse load_done next cycle, go to START.
  - Else: rom_addr+1, go to LOAD_HI.
  - Per-word minimum latency is 3 cycles with a continuously valid source.
- START: cpu_rst=1, cpu_en=0 for one cycle; cyc_count cleared; then RUN.
- run_req in IDLE goes to START and runs the existing ROM contents.
- RUN: cpu_rst=0, cpu_en=1, cyc_count+1 per cycle.
  - halt_req: HALT, with cpu_en=0 from the next cycle.
- HALT: cpu_rst=0, cpu_en=0; CPU state is preserved.
  - run_req: RUN.
  - step_req: STEP.
- STEP: cpu_en=1 for exactly one cycle, cyc_count+1, then HALT. Requests arriving during STEP other than load_req are dropped.
- cyc_count wraps modulo 2**CNT_W.
- step_req or halt_req in IDLE is ignored.
- Async reset mid-load aborts the load. Partially written ROM is not cleared; the sequencer returns to IDLE.

Decomposition:
- Shared package cpu_pkg holds:
  - boot_state_t enum: IDLE=0, LOAD_HI=1, LOAD_LO=2, WRITE=3, START=4, RUN=5, HALT=6, STEP=7.
  - ROM_ADDR_W=15.
- One sub-module, byte_packer: byte handshake to 16-bit word assembly with a word_valid pulse.
- FSM, address counter and cycle counter remain in boot_sequencer.

Test Plan:
- Reset, then idle 5 cycles -> cpu_rst=1, cpu_en=0, byte_ready=0, state_o=0.
- load_req, len_words=2, bytes 0x00,0x07,0xEC,0x10 back-to-back -> rom_we at addr 0 data 0x0007, addr 1 data 0xEC10; load_done pulse; START with cpu_rst=1 for one cycle; then RUN with cpu_en=1.
- Same load with byte_valid deasserted 3 cycles between bytes -> identical ROM writes, no byte lost or duplicated, byte_ready stays 1 in LOAD_HI/LOAD_LO.
- load_req with len_words=0, then with 0x8001 -> load_err pulse each time, state unchanged, no rom_we.
- RUN 10 cycles, halt_req, step_req x3 -> cyc_count=13, each STEP gives exactly one cpu_en cycle, cpu_en=0 otherwise in HALT.
- halt_req and load_req on the same cycle in RUN -> load wins (LOAD_HI, cpu_rst=1). Assert rst during LOAD_LO -> immediate IDLE, all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the Hack CPU boot path: sequencer state encoding and ROM geometry.
package cpu_pkg;

  localparam int unsigned ROM_ADDR_W = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    START   = 3'd4,
    RUN     = 3'd5,
    HALT    = 3'd6,
    STEP    = 3'd7
  } boot_state_t;

  // A load must cover at least one word and fit in the ROM.
  function automatic logic len_legal(input logic [15:0] len, input int unsigned addr_w);
    return (len != 16'd0) && (32'(len) <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Host-side bundle of the boot sequencer: byte stream, ROM write port, CPU control and status.
interface boot_sequencer_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CNT_W  = 32
);

  logic              load_req;
  logic [15:0]       len_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_rst;
  logic              cpu_en;
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic              load_done;
  logic              load_err;
  logic [CNT_W-1:0]  cyc_count;
  logic [2:0]        state_o;

  modport master (
    output load_req, len_words, byte_valid, byte_data, run_req, halt_req, step_req,
    input  byte_ready, rom_we, rom_addr, rom_wdata, cpu_rst, cpu_en, load_done, load_err,
           cyc_count, state_o
  );

  modport slave (
    input  load_req, len_words, byte_valid, byte_data, run_req, halt_req, step_req,
    output byte_ready, rom_we, rom_addr, rom_wdata, cpu_rst, cpu_en, load_done, load_err,
           cyc_count, state_o
  );

endinterface

// File: rtl/boot_sequencer_byte_packer.sv
// Assembles big-endian 16-bit words from a ready/valid byte stream.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic        sel_lo,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_fire,
  output logic        word_valid,
  output logic [15:0] word
);

  assign byte_fire  = ready & byte_valid;
  assign word_valid = byte_fire & sel_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= 16'h0000;
    end else if (byte_fire) begin
      if (sel_lo) word[7:0]  <= byte_data;
      else        word[15:8] <= byte_data;
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// Loads program words into instruction ROM, then runs/halts/steps the CPU through cpu_rst/cpu_en.
module boot_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned CNT_W  = 32
) (
  input logic             clk,
  input logic             rst,
  boot_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_LOAD_HI = LOAD_HI;
  localparam logic [2:0] ST_LOAD_LO = LOAD_LO;
  localparam logic [2:0] ST_WRITE   = WRITE;
  localparam logic [2:0] ST_START   = START;
  localparam logic [2:0] ST_RUN     = RUN;
  localparam logic [2:0] ST_HALT    = HALT;
  localparam logic [2:0] ST_STEP    = STEP;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              byte_ready_q, rom_we_q, cpu_rst_q, cpu_en_q, load_done_q, load_err_q;

  logic              can_load, load_seen, load_ok, load_bad, is_last;
  logic              byte_fire, word_valid;
  logic [15:0]       word;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .ready      (byte_ready_q),
    .sel_lo     (state_q == ST_LOAD_LO),
    .byte_valid (bus.byte_valid),
    .byte_data  (bus.byte_data),
    .byte_fire  (byte_fire),
    .word_valid (word_valid),
    .word       (word)
  );

  assign can_load  = state_q inside {ST_IDLE, ST_RUN, ST_HALT, ST_STEP};
  assign load_seen = can_load & bus.load_req;
  assign load_ok   = load_seen & len_legal(bus.len_words, ADDR_W);
  assign load_bad  = load_seen & ~len_legal(bus.len_words, ADDR_W);
  assign is_last   = (addr_q == last_q);

  // An accepted load_req (legal or not) masks every other request that cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    if (load_ok) begin
      state_d = ST_LOAD_HI;
      addr_d  = '0;
      last_d  = ADDR_W'(bus.len_words - 16'd1);
    end else if (!load_seen) begin
      case (state_q)
        ST_IDLE:    if (bus.run_req) state_d = ST_START;
        ST_LOAD_HI: if (byte_fire) state_d = ST_LOAD_LO;
        ST_LOAD_LO: if (word_valid) state_d = ST_WRITE;
        ST_WRITE: begin
          if (is_last) begin
            state_d = ST_START;
          end else begin
            state_d = ST_LOAD_HI;
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
        ST_START:   state_d = ST_RUN;
        ST_RUN:     if (bus.halt_req) state_d = ST_HALT;
        ST_HALT: begin
          if (bus.halt_req)      state_d = ST_HALT;
          else if (bus.run_req)  state_d = ST_RUN;
          else if (bus.step_req) state_d = ST_STEP;
        end
        ST_STEP:    state_d = ST_HALT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // cpu_en_q marks a cycle the CPU actually advanced; count it as that cycle closes.
  always_comb begin
    cyc_d = cyc_q;
    if (state_d == ST_START) cyc_d = '0;
    else if (cpu_en_q)       cyc_d = cyc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      last_q       <= '0;
      cyc_q        <= '0;
      byte_ready_q <= 1'b0;
      rom_we_q     <= 1'b0;
      cpu_rst_q    <= 1'b1;
      cpu_en_q     <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      cyc_q        <= cyc_d;
      byte_ready_q <= state_d inside {ST_LOAD_HI, ST_LOAD_LO};
      rom_we_q     <= (state_d == ST_WRITE);
      cpu_rst_q    <= state_d inside {ST_IDLE, ST_LOAD_HI, ST_LOAD_LO, ST_WRITE, ST_START};
      cpu_en_q     <= state_d inside {ST_RUN, ST_STEP};
      load_done_q  <= (state_q == ST_WRITE) & is_last;
      load_err_q   <= load_bad;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.rom_we     = rom_we_q;
  assign bus.rom_addr   = addr_q;
  assign bus.rom_wdata  = word;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.cpu_en     = cpu_en_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;
  assign bus.cyc_count  = cyc_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: loads, run/halt/step accounting, errors, priority, reset.
module tb_boot_sequencer;

  localparam int unsigned AW = 15;
  localparam int unsigned CW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  boot_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  boot_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Observation only: collected ROM writes and pulse/enable tallies.
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int en_cnt   = 0;

  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      wr_addr_q.push_back(bus.rom_addr);
      wr_data_q.push_back(bus.rom_wdata);
    end
    if (bus.load_done === 1'b1) done_cnt++;
    if (bus.load_err === 1'b1)  err_cnt++;
    if (bus.cpu_en === 1'b1)    en_cnt++;
  end

  logic [15:0] words[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_req   = 1'b0;
    bus.len_words  = 16'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    bus.run_req    = 1'b0;
    bus.halt_req   = 1'b0;
    bus.step_req   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state_o); end
    checks++; if (bus.cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst got %b want 1", bus.cpu_rst); end
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b want 0", bus.cpu_en); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got %b want 0", bus.byte_ready); end
    checks++; if (bus.rom_we !== 1'b0) begin errors++; $display("FAIL reset_rom_we got %b want 0", bus.rom_we); end
    checks++; if (bus.cyc_count !== '0) begin errors++; $display("FAIL reset_cyc_count got %0d want 0", bus.cyc_count); end
  endtask

  task automatic test_idle_requests();
    bus.step_req = 1'b1; tick(); bus.step_req = 1'b0;
    bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL idle_ignore got state %0d want 0", bus.state_o); end
    bus.run_req = 1'b1; tick(); bus.run_req = 1'b0;
    checks++; if (bus.state_o !== 3'd4 || bus.cpu_rst !== 1'b1) begin
      errors++; $display("FAIL idle_run_start got state %0d rst %b want 4/1", bus.state_o, bus.cpu_rst); end
    tick();
    checks++; if (bus.state_o !== 3'd5 || bus.cpu_en !== 1'b1) begin
      errors++; $display("FAIL idle_run_run got state %0d en %b want 5/1", bus.state_o, bus.cpu_en); end
    bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    checks++; if (bus.state_o !== 3'd6 || bus.cyc_count !== 32'd1) begin
      errors++; $display("FAIL idle_run_halt got state %0d cnt %0d want 6/1", bus.state_o, bus.cyc_count); end
  endtask

  // Loads the contents of words[]; returns in the first RUN cycle.
  task automatic do_load(input string tag, input int len, input int max_gap, input bit fixed_gap);
    int wbase = wr_addr_q.size();
    int dbase = done_cnt;
    int t0;
    int waited;
    int gap;
    logic [15:0] w;
    bus.load_req = 1'b1; bus.len_words = 16'(len); tick();
    bus.load_req = 1'b0;
    t0 = cycle;
    checks++; if (bus.state_o !== 3'd1 || bus.cpu_rst !== 1'b1 || bus.cpu_en !== 1'b0) begin
      errors++; $display("FAIL %s_enter got state %0d rst %b en %b want 1/1/0", tag, bus.state_o, bus.cpu_rst, bus.cpu_en); end
    for (int i = 0; i < 2 * len; i++) begin
      w = words[i / 2];
      gap = fixed_gap ? max_gap : int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        bus.byte_valid = 1'b0;
        // The cycle right after a completed word is its ROM write; ready is low only there.
        checks++; if (bus.byte_ready !== !((i % 2 == 0) && (i > 0) && (g == 0))) begin
          errors++; $display("FAIL %s_ready_gap byte %0d gap %0d got %b", tag, i, g, bus.byte_ready); end
        tick();
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = (i % 2 == 0) ? w[15:8] : w[7:0];
      waited = 0;
      while (bus.byte_ready !== 1'b1 && waited < 8) begin tick(); waited++; end
      if (waited >= 8) begin
        checks++; errors++; $display("FAIL %s_ready_timeout byte %0d got ready %b want 1", tag, i, bus.byte_ready);
      end
      tick();
      bus.byte_valid = 1'b0;
    end
    waited = 0;
    while (bus.load_done !== 1'b1 && waited < 10) begin tick(); waited++; end
    checks++; if (bus.load_done !== 1'b1) begin
      errors++; $display("FAIL %s_done_timeout got load_done %b want 1", tag, bus.load_done); end
    if (max_gap == 0) begin
      checks++; if (cycle - t0 != 3 * len) begin
        errors++; $display("FAIL %s_latency got %0d want %0d", tag, cycle - t0, 3 * len); end
    end
    checks++; if (bus.state_o !== 3'd4 || bus.cpu_rst !== 1'b1 || bus.cpu_en !== 1'b0 || bus.cyc_count !== '0) begin
      errors++; $display("FAIL %s_start got state %0d rst %b en %b cnt %0d want 4/1/0/0", tag,
                         bus.state_o, bus.cpu_rst, bus.cpu_en, bus.cyc_count); end
    checks++; if (wr_addr_q.size() - wbase != len) begin
      errors++; $display("FAIL %s_write_count got %0d want %0d", tag, wr_addr_q.size() - wbase, len); end
    for (int i = 0; i < len && wbase + i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[wbase + i] !== AW'(i) || wr_data_q[wbase + i] !== words[i]) begin
        errors++; $display("FAIL %s_write%0d got addr %0d data %h want %0d %h", tag, i,
                           wr_addr_q[wbase + i], wr_data_q[wbase + i], i, words[i]); end
    end
    tick();
    checks++; if (bus.state_o !== 3'd5 || bus.cpu_rst !== 1'b0 || bus.cpu_en !== 1'b1 || bus.load_done !== 1'b0) begin
      errors++; $display("FAIL %s_run got state %0d rst %b en %b done %b want 5/0/1/0", tag,
                         bus.state_o, bus.cpu_rst, bus.cpu_en, bus.load_done); end
    checks++; if (done_cnt - dbase != 1) begin
      errors++; $display("FAIL %s_done_pulses got %0d want 1", tag, done_cnt - dbase); end
  endtask

  task automatic test_load_b2b();
    words.delete(); words.push_back(16'h0007); words.push_back(16'hEC10);
    do_load("b2b", 2, 0, 1'b0);
  endtask

  task automatic test_load_gaps();
    words.delete(); words.push_back(16'h0007); words.push_back(16'hEC10);
    do_load("gaps", 2, 3, 1'b1);
  endtask

  // Entered in the first RUN cycle after START; leaves the CPU halted.
  task automatic test_run_halt_step(input int n_run, input int n_step);
    int ebase = en_cnt;
    int gap;
    repeat (n_run - 1) tick();
    bus.halt_req = 1'b1; tick(); bus.halt_req = 1'b0;
    checks++; if (bus.state_o !== 3'd6 || bus.cpu_en !== 1'b0 || bus.cyc_count !== CW'(n_run)) begin
      errors++; $display("FAIL rhs_halt got state %0d en %b cnt %0d want 6/0/%0d", bus.state_o, bus.cpu_en,
                         bus.cyc_count, n_run); end
    for (int k = 0; k < n_step; k++) begin
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL rhs_halt_en got %b want 0", bus.cpu_en); end
        tick();
      end
      bus.step_req = 1'b1; tick(); bus.step_req = 1'b0;
      bus.run_req = (k == 0);  // must be dropped while stepping
      checks++; if (bus.state_o !== 3'd7 || bus.cpu_en !== 1'b1) begin
        errors++; $display("FAIL rhs_step%0d got state %0d en %b want 7/1", k, bus.state_o, bus.cpu_en); end
      tick(); bus.run_req = 1'b0;
      checks++; if (bus.state_o !== 3'd6 || bus.cpu_en !== 1'b0) begin
        errors++; $display("FAIL rhs_after_step%0d got state %0d en %b want 6/0", k, bus.state_o, bus.cpu_en); end
    end
    checks++; if (bus.cyc_count !== CW'(n_run + n_step)) begin
      errors++; $display("FAIL rhs_count got %0d want %0d", bus.cyc_count, n_run + n_step); end
    checks++; if (en_cnt - ebase != n_run + n_step) begin
      errors++; $display("FAIL rhs_en_cycles got %0d want %0d", en_cnt - ebase, n_run + n_step); end
  endtask

  task automatic test_load_err();
    logic [15:0] bad[3];
    int ebase;
    int wbase;
    bad[0] = 16'h0000; bad[1] = 16'h8001; bad[2] = 16'($urandom_range(16'hFFFF, 16'h8001));
    for (int j = 0; j < 3; j++) begin
      ebase = err_cnt; wbase = wr_addr_q.size();
      bus.load_req = 1'b1; bus.len_words = bad[j]; tick(); bus.load_req = 1'b0;
      checks++; if (bus.load_err !== 1'b1 || bus.state_o !== 3'd6) begin
        errors++; $display("FAIL err_pulse len %h got err %b state %0d want 1/6", bad[j], bus.load_err, bus.state_o); end
      tick();
      checks++; if (bus.load_err !== 1'b0 || bus.state_o !== 3'd6 || err_cnt - ebase != 1 || wr_addr_q.size() != wbase) begin
        errors++; $display("FAIL err_after len %h got err %b state %0d pulses %0d writes %0d want 0/6/1/0", bad[j],
                           bus.load_err, bus.state_o, err_cnt - ebase, wr_addr_q.size() - wbase); end
    end
  endtask

  task automatic test_random_loads();
    int len;
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(5, 1));
      words.delete();
      for (int i = 0; i < len; i++) words.push_back(16'($urandom()));
      do_load("rand", len, int'($urandom_range(2, 0)), 1'b0);
      test_run_halt_step(int'($urandom_range(15, 2)), int'($urandom_range(4, 1)));
    end
  endtask

  // Entered in RUN; load must beat halt, then an async reset aborts mid-load.
  task automatic test_priority_and_reset();
    bus.halt_req = 1'b1; bus.load_req = 1'b1; bus.len_words = 16'd3; tick();
    bus.halt_req = 1'b0; bus.load_req = 1'b0;
    checks++; if (bus.state_o !== 3'd1 || bus.cpu_rst !== 1'b1 || bus.cpu_en !== 1'b0) begin
      errors++; $display("FAIL prio_load got state %0d rst %b en %b want 1/1/0", bus.state_o, bus.cpu_rst, bus.cpu_en); end
    bus.byte_valid = 1'b1; bus.byte_data = 8'($urandom_range(255, 1)); tick(); bus.byte_valid = 1'b0;
    checks++; if (bus.state_o !== 3'd2) begin errors++; $display("FAIL prio_lo got state %0d want 2", bus.state_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.state_o !== 3'd0 || bus.cpu_rst !== 1'b1 || bus.cpu_en !== 1'b0 || bus.byte_ready !== 1'b0 ||
                  bus.rom_we !== 1'b0 || bus.rom_addr !== '0 || bus.rom_wdata !== 16'h0000 ||
                  bus.cyc_count !== '0 || bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin
      errors++; $display("FAIL async_reset got state %0d rst %b en %b rdy %b we %b addr %0d data %h cnt %0d",
                         bus.state_o, bus.cpu_rst, bus.cpu_en, bus.byte_ready, bus.rom_we, bus.rom_addr,
                         bus.rom_wdata, bus.cyc_count); end
    tick(); rst = 1'b0; tick();
    checks++; if (bus.state_o !== 3'd0 || bus.byte_ready !== 1'b0) begin
      errors++; $display("FAIL post_reset got state %0d rdy %b want 0/0", bus.state_o, bus.byte_ready); end
  endtask

  initial begin
    test_reset();
    test_idle_requests();
    test_load_b2b();
    test_run_halt_step(10, 3);
    test_load_err();
    test_load_gaps();
    test_run_halt_step(int'($urandom_range(12, 2)), 2);
    test_random_loads();
    words.delete(); words.push_back(16'($urandom())); words.push_back(16'($urandom()));
    do_load("pre_prio", 2, 1, 1'b0);
    test_priority_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
